segre_if_fetch_queue: RTL and testbench
=======================================

Name: segre_if_fetch_queue

Overview:
Parametrised instruction-fetch stage for the Segre core. It replaces the single-register IF output with a FIFO fetch queue of FQ_DEPTH {pc, instr} entries, drained by ID through a valid/ready handshake. It issues one icache lookup per cycle and blocks on misses until the MMU refill completes. It flushes on taken branches and has a selectable branch policy: stall on branch, or continue fetching sequentially (predict not-taken).

Parameters:
ADDR_SIZE, 32, pc / address width
WORD_SIZE, 32, instruction width
FQ_DEPTH, 4, fetch queue entries; power of 2, minimum 2
BRANCH_STALL, 1, 1 = stop fetching after BRANCH/JAL/JALR until resolved; 0 = keep fetching pc+4
RESET_PC, 0, pc after reset

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
ic_req_o  out  1  icache lookup request this cycle
ic_addr_o  out  ADDR_SIZE  lookup pc; latched miss address while in F_MISS
ic_hit_i  in  1  same-cycle hit for ic_req_o
ic_miss_i  in  1  same-cycle miss for ic_req_o
ic_data_i  in  WORD_SIZE  instruction word, valid with ic_hit_i
mmu_data_i  in  1  refill of the missed line completes this cycle
tkbr_i  in  1  taken branch / redirect from WB
new_pc_i  in  ADDR_SIZE  redirect target
branch_completed_i  in  1  outstanding branch resolved (taken or not)
valid_o  out  1  head entry valid
ready_i  in  1  ID accepts head entry
instr_o  out  WORD_SIZE  head instruction; NOP (0x00000013) when empty
pc_o  out  ADDR_SIZE  head pc; 0 when empty
fq_count_o  out  $clog2(FQ_DEPTH)+1  occupancy
fetch_stall_o  out  1  high in F_MISS or F_BRSTALL

Behaviour:
- Reset (rst_i=1 at posedge): pc=RESET_PC; queue empty, pointers 0; state F_RUN; valid_o=0, instr_o=NOP, pc_o=0, fq_count_o=0, fetch_stall_o=0. While rst_i=1, ic_req_o=0.
- FSM states: F_RUN, F_MISS, F_BRSTALL.
- ic_req_o = (state==F_RUN) && count<FQ_DEPTH && !tkbr_i && !rst_i. A full queue blocks the request even if a pop occurs the same cycle (one-cycle bubble, by design).
- F_RUN, request with ic_hit_i: push {pc, ic_data_i}; pc<=pc+4, wrapping modulo 2^ADDR_SIZE. If ic_data_i[6:0] is BRANCH/JAL/JALR and BRANCH_STALL=1: go to F_BRSTALL.
- F_RUN, request with ic_miss_i: no push; miss_addr<=pc; pc held; go to F_MISS. If ic_hit_i and ic_miss_i are both high, treat as a miss (also a protocol assertion).
- F_MISS: ic_req_o=0; ic_addr_o=miss_addr. On mmu_data_i go to F_RUN; pc is re-looked-up the next cycle. mmu_data_i outside F_MISS is ignored.
- F_BRSTALL: ic_req_o=0. On branch_completed_i or tkbr_i go to F_RUN.
- Redirect (tkbr_i, highest priority): queue flushed (count=0, pointers 0); any same-cycle pop and push are discarded; pc<=new_pc_i with bits [1:0] forced to 0.
  - From F_RUN or F_BRSTALL: next state F_RUN.
  - From F_MISS: stay in F_MISS until mmu_data_i. The refill must complete; miss_addr is unchanged, then the new pc is fetched.
- Output side is first-word-fall-through: valid_o=(count!=0); instr_o/pc_o show the head combinationally. Pop when valid_o && ready_i.
  - Push and pop in the same cycle: count unchanged.
  - Pop on empty: impossible, since valid_o=0.
- fq_count_o is registered occupancy, range 0..FQ_DEPTH. Pointers wrap modulo FQ_DEPTH.
- Latency: a hit at cycle N is visible on valid_o/instr_o at cycle N+1.
- Reset mid-miss or mid-branch: immediate return to the reset state; a later mmu_data_i is ignored.

Test Plan:
1. Reset, then 6 consecutive hits with ready_i=1, pc 0..0x14 -> valid_o from cycle 1; pc_o sequence 0,4,8,0xC,0x10,0x14; fq_count_o stays at 1.
2. ready_i=0, hits continuous, FQ_DEPTH=4 -> fq_count_o reaches 4, ic_req_o drops to 0, pc=0x10. ready_i=1 for one cycle -> count 3, the next cycle ic_req_o=1 for pc 0x10.
3. Miss at pc 0x8 -> F_MISS, ic_addr_o=0x8, fetch_stall_o=1. mmu_data_i 5 cycles later -> F_RUN, next cycle ic_req_o=1 with ic_addr_o=0x8; hit pushes pc 0x8.
4. BRANCH_STALL=1, BEQ fetched at 0x4 -> no requests until branch_completed_i. With tkbr_i=1, new_pc_i=0x103 the same cycle -> queue flushed, next lookup at 0x100.
5. BRANCH_STALL=0, queue holds 3 entries, tkbr_i=1 with new_pc_i=0x40 while ready_i=1 -> count=0, valid_o=0 next cycle, next lookup at 0x40, no stale entry ever delivered.
6. tkbr_i (new_pc_i=0x80) during F_MISS on 0x20 -> ic_addr_o remains 0x20 until mmu_data_i. Then next lookup is 0x80. Separately, rst_i mid-miss -> pc=RESET_PC, state F_RUN, and a later mmu_data_i has no effect.

Source files
------------

// File: rtl/segre_if_fetch_queue.sv
// rtl/segre_if_fetch_queue.sv - Segre instruction fetch stage with a FIFO fetch queue
//
// Purpose: issues one icache lookup per cycle and pushes each hit into a
// FQ_DEPTH-entry {pc, instr} queue. ID drains the queue through valid/ready.
// Fetch blocks on a miss until the MMU refill completes. A taken branch
// flushes the queue. With BRANCH_STALL=1, fetch optionally stalls after
// BRANCH/JAL/JALR.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   ic_req_o, ic_addr_o   icache lookup request and address
//   ic_hit_i, ic_miss_i   same-cycle lookup result
//   ic_data_i             fetched instruction word (valid with ic_hit_i)
//   mmu_data_i            refill of the missed line completes
//   tkbr_i, new_pc_i      redirect from WB and its target
//   branch_completed_i    outstanding branch resolved
//   valid_o, ready_i      head-entry handshake towards ID
//   instr_o, pc_o         head entry (NOP / 0 when empty)
//   fq_count_o            queue occupancy
//   fetch_stall_o         fetch blocked on a miss or a branch
module segre_if_fetch_queue #(
    parameter int                   ADDR_SIZE    = 32,
    parameter int                   WORD_SIZE    = 32,
    parameter int                   FQ_DEPTH     = 4,
    parameter int                   BRANCH_STALL = 1,
    parameter logic [ADDR_SIZE-1:0] RESET_PC     = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    output logic                         ic_req_o,
    output logic [ADDR_SIZE-1:0]         ic_addr_o,
    input  logic                         ic_hit_i,
    input  logic                         ic_miss_i,
    input  logic [WORD_SIZE-1:0]         ic_data_i,
    input  logic                         mmu_data_i,
    input  logic                         tkbr_i,
    input  logic [ADDR_SIZE-1:0]         new_pc_i,
    input  logic                         branch_completed_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [WORD_SIZE-1:0]         instr_o,
    output logic [ADDR_SIZE-1:0]         pc_o,
    output logic [$clog2(FQ_DEPTH):0]    fq_count_o,
    output logic                         fetch_stall_o
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [WORD_SIZE-1:0] NOP = WORD_SIZE'(32'h0000_0013);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {F_RUN, F_MISS, F_BRSTALL} fstate_e;

    fstate_e              state_q, state_d;
    logic [ADDR_SIZE-1:0] pc_q, pc_d;
    logic [ADDR_SIZE-1:0] miss_addr_q, miss_addr_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [ADDR_SIZE-1:0] fq_pc_q [FQ_DEPTH];
    logic [ADDR_SIZE-1:0] fq_pc_d [FQ_DEPTH];
    logic [WORD_SIZE-1:0] fq_instr_q [FQ_DEPTH];
    logic [WORD_SIZE-1:0] fq_instr_d [FQ_DEPTH];

    logic ic_req;
    logic push;
    logic pop;
    logic is_branch;

    always_comb begin
        // A full queue blocks the lookup even when ID pops this cycle; this
        // keeps the request independent of ready_i.
        ic_req    = (state_q == F_RUN) && (count_q < CW'(FQ_DEPTH)) && !tkbr_i && !rst_i;
        // Hit and miss together counts as a miss.
        push      = ic_req && ic_hit_i && !ic_miss_i;
        pop       = (count_q != '0) && ready_i;
        is_branch = (ic_data_i[6:0] == OP_BRANCH) || (ic_data_i[6:0] == OP_JAL)
                 || (ic_data_i[6:0] == OP_JALR);

        state_d     = state_q;
        pc_d        = pc_q;
        miss_addr_d = miss_addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        fq_pc_d     = fq_pc_q;
        fq_instr_d  = fq_instr_q;

        if (tkbr_i) begin
            // A redirect drops the queue. Any same-cycle pop is discarded.
            // An outstanding refill must still complete before fetching again.
            pc_d     = {new_pc_i[ADDR_SIZE-1:2], 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            state_d  = (state_q == F_MISS && !mmu_data_i) ? F_MISS : F_RUN;
        end else begin
            if (push) begin
                fq_pc_d[wr_ptr_q]    = pc_q;
                fq_instr_d[wr_ptr_q] = ic_data_i;
                wr_ptr_d             = wr_ptr_q + PW'(1);
                pc_d                 = pc_q + ADDR_SIZE'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            case (state_q)
                F_RUN: begin
                    if (ic_req && ic_miss_i) begin
                        miss_addr_d = pc_q;
                        state_d     = F_MISS;
                    end else if (push && is_branch && (BRANCH_STALL != 0)) begin
                        state_d = F_BRSTALL;
                    end
                end
                F_MISS: begin
                    if (mmu_data_i) begin
                        state_d = F_RUN;
                    end
                end
                F_BRSTALL: begin
                    if (branch_completed_i) begin
                        state_d = F_RUN;
                    end
                end
                default: state_d = F_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= F_RUN;
            pc_q        <= RESET_PC;
            miss_addr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            miss_addr_q <= miss_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Queue storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk_i) begin
        fq_pc_q    <= fq_pc_d;
        fq_instr_q <= fq_instr_d;
    end

    assign ic_req_o      = ic_req;
    assign ic_addr_o     = (state_q == F_MISS) ? miss_addr_q : pc_q;
    assign valid_o       = (count_q != '0);
    assign instr_o       = valid_o ? fq_instr_q[rd_ptr_q] : NOP;
    assign pc_o          = valid_o ? fq_pc_q[rd_ptr_q] : '0;
    assign fq_count_o    = count_q;
    assign fetch_stall_o = (state_q != F_RUN);

    hit_miss_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
        ic_req_o |-> !(ic_hit_i && ic_miss_i));

endmodule

// File: tb/tb_segre_if_fetch_queue.sv
// tb/tb_segre_if_fetch_queue.sv - scoreboard bench for segre_if_fetch_queue
module tb_segre_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        ic_req_o;
    logic [31:0] ic_addr_o;
    logic        ic_hit_i = 1'b0;
    logic        ic_miss_i = 1'b0;
    logic [31:0] ic_data_i = '0;
    logic        mmu_data_i = 1'b0;
    logic        tkbr_i = 1'b0;
    logic [31:0] new_pc_i = '0;
    logic        branch_completed_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [2:0]  fq_count_o;
    logic        fetch_stall_o;

    int checks = 0;
    int failures = 0;
    logic [63:0] sb[$];
    logic        flush_pend = 1'b0;

    always #5 clk = ~clk;

    segre_if_fetch_queue #(
        .ADDR_SIZE(32), .WORD_SIZE(32), .FQ_DEPTH(4), .BRANCH_STALL(1), .RESET_PC(32'h0)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .ic_req_o(ic_req_o), .ic_addr_o(ic_addr_o),
        .ic_hit_i(ic_hit_i), .ic_miss_i(ic_miss_i), .ic_data_i(ic_data_i),
        .mmu_data_i(mmu_data_i), .tkbr_i(tkbr_i), .new_pc_i(new_pc_i),
        .branch_completed_i(branch_completed_i), .valid_o(valid_o), .ready_i(ready_i),
        .instr_o(instr_o), .pc_o(pc_o), .fq_count_o(fq_count_o), .fetch_stall_o(fetch_stall_o)
    );

    function automatic logic [31:0] ins(input logic [31:0] a);
        return {a[11:0], 20'h00013};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=0x%08h required=0x%08h", name, $time, act, exp);
        end
    endtask

    // Monitor: every accepted head entry must match the oldest expected push.
    always @(negedge clk) begin
        if (!rst_i && valid_o && ready_i && !tkbr_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_pop_pc", pc_o, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("sb_pc", pc_o, e[63:32]);
                chk("sb_instr", instr_o, e[31:0]);
            end
        end
    end

    task automatic step(input logic hit, input logic miss, input logic mmu, input logic tk,
                        input logic [31:0] npc, input logic bc, input logic rdy,
                        input logic [31:0] data, input logic e_req, input logic [31:0] e_addr,
                        input int e_cnt, input logic e_stall);
        @(posedge clk);
        #1;
        if (flush_pend) begin
            sb.delete();
            flush_pend = 1'b0;
        end
        rst_i = 1'b0;
        ic_hit_i = hit; ic_miss_i = miss; mmu_data_i = mmu; tkbr_i = tk;
        new_pc_i = npc; branch_completed_i = bc; ready_i = rdy; ic_data_i = data;
        if (e_req && hit && !miss && !tk) sb.push_back({e_addr, data});
        if (tk) flush_pend = 1'b1;
        @(negedge clk);
        chk("ic_req", 32'(ic_req_o), 32'(e_req));
        chk("ic_addr", ic_addr_o, e_addr);
        chk("fq_count", 32'(fq_count_o), 32'(e_cnt));
        chk("fetch_stall", 32'(fetch_stall_o), 32'(e_stall));
        chk("valid", 32'(valid_o), 32'(e_cnt != 0));
        if (e_cnt == 0) begin
            chk("empty_instr", instr_o, 32'h0000_0013);
            chk("empty_pc", pc_o, 32'h0);
        end
    endtask

    task automatic hitv(input logic [31:0] a, input int cnt, input logic rdy);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, rdy, ins(a), 1'b1, a, cnt, 1'b0);
    endtask

    task automatic idle(input logic [31:0] a, input logic req, input int cnt,
                        input logic rdy, input logic stall);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, rdy, 32'h0, req, a, cnt, stall);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        ic_hit_i = 1'b0; ic_miss_i = 1'b0; mmu_data_i = 1'b0; tkbr_i = 1'b0;
        new_pc_i = '0; branch_completed_i = 1'b0; ready_i = 1'b0; ic_data_i = '0;
        sb.delete();
        flush_pend = 1'b0;
        @(negedge clk);
        chk("reset_req", 32'(ic_req_o), 32'h0);
    endtask

    initial begin
        // 1: streaming hits with ID always ready
        do_reset();
        for (int k = 0; k < 6; k++) hitv(32'(4 * k), (k == 0) ? 0 : 1, 1'b1);
        idle(32'h18, 1'b1, 1, 1'b1, 1'b0);
        idle(32'h18, 1'b1, 0, 1'b1, 1'b0);

        // 2: fill to full, one-cycle bubble after a pop
        do_reset();
        for (int k = 0; k < 4; k++) hitv(32'(4 * k), k, 1'b0);
        idle(32'h10, 1'b0, 4, 1'b0, 1'b0);
        idle(32'h10, 1'b0, 4, 1'b1, 1'b0);
        hitv(32'h10, 3, 1'b0);
        idle(32'h14, 1'b0, 4, 1'b1, 1'b0);
        idle(32'h14, 1'b1, 3, 1'b1, 1'b0);
        idle(32'h14, 1'b1, 2, 1'b1, 1'b0);
        idle(32'h14, 1'b1, 1, 1'b1, 1'b0);
        idle(32'h14, 1'b1, 0, 1'b1, 1'b0);

        // 3: miss at 0x8, refill, re-lookup
        do_reset();
        hitv(32'h0, 0, 1'b1);
        hitv(32'h4, 1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h8, 1, 1'b0);
        for (int k = 0; k < 5; k++) idle(32'h8, 1'b0, 0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h8, 0, 1'b1);
        hitv(32'h8, 0, 1'b1);
        idle(32'hC, 1'b1, 1, 1'b1, 1'b0);
        idle(32'hC, 1'b1, 0, 1'b1, 1'b0);

        // 4: BEQ at 0x4 stalls; completion with redirect to 0x103 flushes
        do_reset();
        hitv(32'h0, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0063, 1'b1, 32'h4, 1, 1'b0);
        idle(32'h8, 1'b0, 2, 1'b0, 1'b1);
        idle(32'h8, 1'b0, 2, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h103, 1'b1, 1'b1, 32'h0, 1'b0, 32'h8, 2, 1'b1);
        hitv(32'h100, 0, 1'b1);
        idle(32'h104, 1'b1, 1, 1'b1, 1'b0);
        idle(32'h104, 1'b1, 0, 1'b1, 1'b0);

        // 5: redirect with three queued entries while ID is ready
        do_reset();
        hitv(32'h0, 0, 1'b0);
        hitv(32'h4, 1, 1'b0);
        hitv(32'h8, 2, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 32'h0, 1'b0, 32'hC, 3, 1'b0);
        hitv(32'h40, 0, 1'b1);
        idle(32'h44, 1'b1, 1, 1'b1, 1'b0);
        idle(32'h44, 1'b1, 0, 1'b1, 1'b0);

        // 6a: redirect during a miss waits for the refill
        do_reset();
        for (int k = 0; k < 8; k++) hitv(32'(4 * k), (k == 0) ? 0 : 1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h20, 1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b1, 32'h0, 1'b0, 32'h20, 0, 1'b1);
        idle(32'h20, 1'b0, 0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h20, 0, 1'b1);
        hitv(32'h80, 0, 1'b1);
        idle(32'h84, 1'b1, 1, 1'b1, 1'b0);
        idle(32'h84, 1'b1, 0, 1'b1, 1'b0);

        // 6b: reset mid-miss, later refill ignored
        do_reset();
        hitv(32'h0, 0, 1'b1);
        hitv(32'h4, 1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 32'h8, 1, 1'b0);
        idle(32'h8, 1'b0, 0, 1'b1, 1'b1);
        do_reset();
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, ins(32'h0), 1'b1, 32'h0, 0, 1'b0);
        idle(32'h4, 1'b1, 1, 1'b1, 1'b0);
        idle(32'h4, 1'b1, 0, 1'b1, 1'b0);

        @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
